// File: rtl/byte_serial_adder_if.sv
// rtl/byte_serial_adder_if.sv - request/result bundle between a requester and byte_serial_adder
interface byte_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             subtract;
  logic [WIDTH-1:0] source_element_0;
  logic [WIDTH-1:0] source_element_1;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             output_carry;
  logic             overflow;

  modport master (
    output start, subtract, source_element_0, source_element_1,
    input  busy, done, result, output_carry, overflow
  );

  modport slave (
    input  start, subtract, source_element_0, source_element_1,
    output busy, done, result, output_carry, overflow
  );
endinterface

// File: rtl/byte_serial_adder.sv
// rtl/byte_serial_adder.sv - multi-cycle adder/subtractor reusing one 8-bit Kogge-Stone carry network
module carry_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  output logic [7:0] bitwise_carry,
  output logic       output_carry
);
  logic [7:0] g0, p0, g1, p1, g2, p2, g3;

  // Carry-in is folded into bit 0's generate so the prefix tree needs no extra column.
  assign p0 = a ^ b;
  assign g0 = (a & b) | {7'd0, p0[0] & carry_in};

  // Three prefix levels, spans 1, 2 and 4; shifting in zeros/ones keeps low bits as pass-through.
  assign g1 = g0 | (p0 & {g0[6:0], 1'b0});
  assign p1 = p0 & {p0[6:0], 1'b1};
  assign g2 = g1 | (p1 & {g1[5:0], 2'b00});
  assign p2 = p1 & {p1[5:0], 2'b11};
  assign g3 = g2 | (p2 & {g2[3:0], 4'b0000});

  // g3[i] is the carry out of bit i, so the carry into bit i is g3[i-1].
  assign bitwise_carry = {g3[6:0], carry_in};
  assign output_carry  = g3[7];
endmodule

module byte_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  byte_serial_adder_if.slave bus
);
  localparam int NUM_BYTES = WIDTH / 8;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             out_carry_q, out_carry_d;
  logic             overflow_q, overflow_d;
  logic [IDX_W-1:0] byte_index_q, byte_index_d;

  logic [7:0]       a_byte, b_byte, bitwise_carry, byte_sum;
  logic             net_carry;

  // Select the operand byte currently being processed.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (byte_index_q == IDX_W'(i)) begin
        a_byte = op_a_q[8*i +: 8];
        b_byte = op_b_q[8*i +: 8];
      end
    end
  end

  carry_8 u_carry_8 (
    .a             (a_byte),
    .b             (b_byte),
    .carry_in      (carry_q),
    .bitwise_carry (bitwise_carry),
    .output_carry  (net_carry)
  );

  assign byte_sum = a_byte ^ b_byte ^ bitwise_carry;

  // Next-state and datapath updates: accept in IDLE/DONE, one byte per RUN cycle.
  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    result_d     = result_q;
    carry_d      = carry_q;
    out_carry_d  = out_carry_q;
    overflow_d   = overflow_q;
    byte_index_d = byte_index_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          op_a_d       = bus.source_element_0;
          op_b_d       = bus.subtract ? ~bus.source_element_1 : bus.source_element_1;
          carry_d      = bus.subtract;
          byte_index_d = '0;
          result_d     = '0;
          out_carry_d  = 1'b0;
          overflow_d   = 1'b0;
          state_d      = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (byte_index_q == IDX_W'(i)) begin
            result_d[8*i +: 8] = byte_sum;
          end
        end
        carry_d      = net_carry;
        byte_index_d = byte_index_q + IDX_W'(1);
        if (byte_index_q == IDX_W'(NUM_BYTES - 1)) begin
          out_carry_d = net_carry;
          overflow_d  = bitwise_carry[7] ^ net_carry;
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      out_carry_q  <= 1'b0;
      overflow_q   <= 1'b0;
      byte_index_q <= '0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      result_q     <= result_d;
      carry_q      <= carry_d;
      out_carry_q  <= out_carry_d;
      overflow_q   <= overflow_d;
      byte_index_q <= byte_index_d;
    end
  end

  assign bus.busy         = (state_q == RUN);
  assign bus.done         = (state_q == DONE);
  assign bus.result       = result_q;
  assign bus.output_carry = out_carry_q;
  assign bus.overflow     = overflow_q;
endmodule
